odelay_tap_ctrl: RTL and testbench

ODELAY_TAP_CTRL -- requirements
Module: odelay_tap_ctrl

---
 rtl/odelay_ctrl_pkg.sv | 19 +
 rtl/odelay_tap_ctrl.sv | 165 ++++++++++++++++
 tb/tb_odelay_tap_ctrl.sv | 228 ++++++++++++++++++++++
 3 files changed

// File: rtl/odelay_ctrl_pkg.sv
// rtl/odelay_ctrl_pkg.sv - shared widths, defaults and FSM state encoding for the ODELAY tap controller
package odelay_ctrl_pkg;

  localparam int TAP_W       = 9;
  localparam int CNT_W       = 8;
  localparam int MAX_TAP_DEF = 511;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_VTC_OFF,
    ST_LOAD,
    ST_STEP,
    ST_GAP,
    ST_READBACK,
    ST_VTC_ON,
    ST_DONE
  } state_e;

endpackage

// File: rtl/odelay_tap_ctrl.sv
// rtl/odelay_tap_ctrl.sv - ODELAY tap sequencer (EN_VTC off, load or CE/INC walk, optional readback under ODELAY_TAP_CTRL_READBACK_EN)
module odelay_tap_ctrl
  import odelay_ctrl_pkg::*;
#(
  parameter int MAX_TAP    = MAX_TAP_DEF,
  parameter int VTC_SETTLE = 10,
  parameter int STEP_GAP   = 2
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [TAP_W-1:0] req_tap,
  input  logic             req_load,
  output logic             done,
  output logic             busy,
  output logic             err,
  output logic [TAP_W-1:0] cur_tap,
  output logic             dly_ce,
  output logic             dly_inc,
  output logic             dly_load,
  output logic [TAP_W-1:0] dly_cntvaluein,
  output logic             dly_en_vtc,
  input  logic [TAP_W-1:0] dly_cntvalueout
);

  localparam logic [TAP_W-1:0] MAX_V     = TAP_W'(MAX_TAP);
  localparam logic [CNT_W-1:0] SETTLE_LD = CNT_W'(VTC_SETTLE - 1);
  localparam logic [CNT_W-1:0] GAP_LD    = CNT_W'((STEP_GAP > 0) ? STEP_GAP - 1 : 0);

`ifdef ODELAY_TAP_CTRL_READBACK_EN
  localparam state_e           POST_ADJ = ST_READBACK;
  localparam logic [CNT_W-1:0] POST_CNT = CNT_W'(1);
`else
  localparam state_e           POST_ADJ = ST_VTC_ON;
  localparam logic [CNT_W-1:0] POST_CNT = SETTLE_LD;
  logic unused_cntvalueout;
  assign unused_cntvalueout = ^dly_cntvalueout;
`endif

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [TAP_W-1:0]   target_q, target_d;
  logic [TAP_W-1:0]   cur_q, cur_d;
  logic               load_q, load_d;
  logic               err_q, err_d;
  logic               step_up;
  logic [TAP_W-1:0]   cur_step;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      target_q <= '0;
      cur_q    <= '0;
      load_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      target_q <= target_d;
      cur_q    <= cur_d;
      load_q   <= load_d;
      err_q    <= err_d;
    end
  end

  // Saturating one-tap move toward the target; never wraps past 0 or MAX_TAP.
  assign step_up  = (target_q > cur_q);
  assign cur_step = step_up ? ((cur_q == MAX_V) ? cur_q : cur_q + 1'b1)
                            : ((cur_q == '0)    ? cur_q : cur_q - 1'b1);

  always_comb begin
    state_d        = state_q;
    cnt_d          = (cnt_q != '0) ? cnt_q - 1'b1 : '0;
    target_d       = target_q;
    cur_d          = cur_q;
    load_d         = load_q;
    err_d          = err_q;
    req_ready      = 1'b0;
    done           = 1'b0;
    busy           = 1'b1;
    dly_ce         = 1'b0;
    dly_inc        = 1'b0;
    dly_load       = 1'b0;
    dly_cntvaluein = '0;
    dly_en_vtc     = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready  = 1'b1;
        busy       = 1'b0;
        dly_en_vtc = 1'b1;
        if (req_valid) begin
          target_d = (req_tap > MAX_V) ? MAX_V : req_tap;
          load_d   = req_load;
          cnt_d    = SETTLE_LD;
          state_d  = ST_VTC_OFF;
        end
      end
      ST_VTC_OFF: begin
        if (cnt_q == '0) begin
          if (load_q) begin
            state_d = ST_LOAD;
          end else if (target_q != cur_q) begin
            state_d = ST_STEP;
          end else begin
            state_d = POST_ADJ;
            cnt_d   = POST_CNT;
          end
        end
      end
      ST_LOAD: begin
        dly_load       = 1'b1;
        dly_cntvaluein = target_q;
        cur_d          = target_q;
        state_d        = POST_ADJ;
        cnt_d          = POST_CNT;
      end
      ST_STEP: begin
        dly_ce  = 1'b1;
        dly_inc = step_up;
        cur_d   = cur_step;
        if (cur_step == target_q) begin
          state_d = POST_ADJ;
          cnt_d   = POST_CNT;
        end else if (STEP_GAP == 0) begin
          state_d = ST_STEP;
        end else begin
          state_d = ST_GAP;
          cnt_d   = GAP_LD;
        end
      end
      ST_GAP: begin
        if (cnt_q == '0) state_d = ST_STEP;
      end
      ST_READBACK: begin
        if (cnt_q == '0) begin
`ifdef ODELAY_TAP_CTRL_READBACK_EN
          if (dly_cntvalueout != cur_q) begin
            err_d = 1'b1;
            cur_d = dly_cntvalueout;
          end
`endif
          state_d = ST_VTC_ON;
          cnt_d   = SETTLE_LD;
        end
      end
      ST_VTC_ON: begin
        dly_en_vtc = 1'b1;
        if (cnt_q == '0) state_d = ST_DONE;
      end
      ST_DONE: begin
        dly_en_vtc = 1'b1;
        done       = 1'b1;
        state_d    = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign cur_tap = cur_q;
  assign err     = err_q;

endmodule

// File: tb/tb_odelay_tap_ctrl.sv
// tb/tb_odelay_tap_ctrl.sv - directed self-checking bench for odelay_tap_ctrl
module tb_odelay_tap_ctrl;

`ifdef ODELAY_TAP_CTRL_READBACK_EN
  localparam int RB_CYC = 2;
`else
  localparam int RB_CYC = 0;
`endif

  logic       CLK, RST;
  logic       req_valid, req_load;
  logic [8:0] req_tap;
  logic       req_ready, done, busy, err;
  logic [8:0] cur_tap, dly_cntvaluein, dly_cntvalueout;
  logic       dly_ce, dly_inc, dly_load, dly_en_vtc;

  logic       u2_ready, u2_done, u2_busy, u2_err;
  logic [8:0] u2_cur, u2_cval;
  logic       u2_ce, u2_inc, u2_load, u2_en_vtc;

  logic [8:0] model_tap;
  logic       corrupt;

  int n_pass, n_checks;
  int cyc, done_cnt, vtc_low, load_cnt, inc_cnt, strobe_bad;
  int load_val, u2_load_val;
  int ce_times[$];
  int b_ce, b_done, b_vtc, b_load, b_inc;

  odelay_tap_ctrl u_dut (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(req_ready),
    .req_tap(req_tap), .req_load(req_load), .done(done), .busy(busy), .err(err),
    .cur_tap(cur_tap), .dly_ce(dly_ce), .dly_inc(dly_inc), .dly_load(dly_load),
    .dly_cntvaluein(dly_cntvaluein), .dly_en_vtc(dly_en_vtc),
    .dly_cntvalueout(dly_cntvalueout)
  );

  // Second instance with a reduced MAX_TAP so the clamp path is reachable through a 9-bit port.
  odelay_tap_ctrl #(.MAX_TAP(300), .VTC_SETTLE(1), .STEP_GAP(0)) u_dut_clamp (
    .CLK(CLK), .RST(RST), .req_valid(req_valid), .req_ready(u2_ready),
    .req_tap(req_tap), .req_load(req_load), .done(u2_done), .busy(u2_busy), .err(u2_err),
    .cur_tap(u2_cur), .dly_ce(u2_ce), .dly_inc(u2_inc), .dly_load(u2_load),
    .dly_cntvaluein(u2_cval), .dly_en_vtc(u2_en_vtc),
    .dly_cntvalueout(u2_cur)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK or posedge RST) begin
    if (RST)           model_tap <= '0;
    else if (dly_load) model_tap <= dly_cntvaluein;
    else if (dly_ce)   model_tap <= dly_inc ? model_tap + 9'd1 : model_tap - 9'd1;
  end
  assign dly_cntvalueout = corrupt ? model_tap - 9'd1 : model_tap;

  always @(negedge CLK) begin
    if (!RST) begin
      if (dly_ce) begin
        ce_times.push_back(cyc);
        if (dly_inc) inc_cnt = inc_cnt + 1;
      end
      if (dly_load) begin
        load_cnt = load_cnt + 1;
        load_val = int'(dly_cntvaluein);
      end
      if ((dly_ce && dly_load) || (!dly_ce && dly_inc)) strobe_bad = strobe_bad + 1;
      if (!dly_en_vtc) vtc_low = vtc_low + 1;
      if (done) done_cnt = done_cnt + 1;
      if (u2_load) u2_load_val = int'(u2_cval);
      cyc = cyc + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic snap();
    b_ce   = ce_times.size();
    b_done = done_cnt;
    b_vtc  = vtc_low;
    b_load = load_cnt;
    b_inc  = inc_cnt;
  endtask

  task automatic run_req(input logic [8:0] tap, input logic ld);
    int n;
    snap();
    @(negedge CLK);
    req_valid = 1'b1; req_tap = tap; req_load = ld;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge CLK); n++; end
    @(posedge CLK); #1;
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 2000) begin @(negedge CLK); n++; end
    check("req_finished_in_time", n < 2000, 1);
    @(negedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    int n, nce, g1, g2;
    n_pass = 0; n_checks = 0;
    cyc = 0; done_cnt = 0; vtc_low = 0; load_cnt = 0; inc_cnt = 0; strobe_bad = 0;
    load_val = 0; u2_load_val = 0;
    corrupt = 1'b0;
    RST = 1'b1; req_valid = 1'b0; req_tap = '0; req_load = 1'b0;
    repeat (3) @(negedge CLK);
    check("rst_ready", req_ready, 1);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_en_vtc", dly_en_vtc, 1);
    check("rst_strobes", {dly_ce, dly_inc, dly_load}, 0);
    check("rst_cntvaluein", dly_cntvaluein, 0);
    check("rst_cur_tap", cur_tap, 0);
    check("rst_err", err, 0);
    RST = 1'b0;
    repeat (2) @(negedge CLK);

    run_req(9'd128, 1'b1);
    check("load128_pulses", load_cnt - b_load, 1);
    check("load128_value", load_val, 128);
    check("load128_ce", ce_times.size() - b_ce, 0);
    check("load128_cur", cur_tap, 128);
    check("load128_done", done_cnt - b_done, 1);
    check("load128_vtc_low", vtc_low - b_vtc, 11 + RB_CYC);
    check("load128_en_vtc_after", dly_en_vtc, 1);
    check("load128_busy_after", busy, 0);

    run_req(9'd131, 1'b0);
    nce = ce_times.size() - b_ce;
    g1 = (nce >= 3) ? ce_times[b_ce+1] - ce_times[b_ce] : -1;
    g2 = (nce >= 3) ? ce_times[b_ce+2] - ce_times[b_ce+1] : -1;
    check("step131_ce", nce, 3);
    check("step131_inc", inc_cnt - b_inc, 3);
    check("step131_gap1", g1, 3);
    check("step131_gap2", g2, 3);
    check("step131_cur", cur_tap, 131);
    check("step131_vtc_low", vtc_low - b_vtc, 17 + RB_CYC);

    run_req(9'd131, 1'b0);
    check("same_ce", ce_times.size() - b_ce, 0);
    check("same_done", done_cnt - b_done, 1);
    check("same_vtc_low", vtc_low - b_vtc, 10 + RB_CYC);

    corrupt = 1'b1;
    run_req(9'd131, 1'b1);
`ifdef ODELAY_TAP_CTRL_READBACK_EN
    check("rb_err_set", err, 1);
    check("rb_cur_overwritten", cur_tap, 130);
    corrupt = 1'b0;
    run_req(9'd131, 1'b1);
    check("rb_err_sticky", err, 1);
    check("rb_cur_clean", cur_tap, 131);
`else
    check("norb_err_zero", err, 0);
    check("norb_cur", cur_tap, 131);
    corrupt = 1'b0;
`endif

    run_req(9'd511, 1'b1);
    check("max_load_value", load_val, 511);
    check("max_cur", cur_tap, 511);
    check("clamp_load_value", u2_load_val, 300);
    check("clamp_cur", u2_cur, 300);

    run_req(9'd2, 1'b1);
    run_req(9'd0, 1'b0);
    check("down_ce", ce_times.size() - b_ce, 2);
    check("down_inc", inc_cnt - b_inc, 0);
    check("down_cur", cur_tap, 0);
    run_req(9'd0, 1'b0);
    check("floor_ce", ce_times.size() - b_ce, 0);
    check("floor_cur", cur_tap, 0);

    snap();
    @(negedge CLK);
    req_valid = 1'b1; req_tap = 9'd20; req_load = 1'b1;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    check("inflight_busy", busy, 1);
    check("inflight_ready", req_ready, 0);
    check("inflight_en_vtc", dly_en_vtc, 0);
    repeat (3) @(negedge CLK);
    req_valid = 1'b1; req_tap = 9'd50; req_load = 1'b1;
    @(negedge CLK);
    req_valid = 1'b0;
    n = 0;
    while (!done && n < 2000) begin @(negedge CLK); n++; end
    check("ignore_finished_in_time", n < 2000, 1);
    repeat (30) @(negedge CLK);
    check("ignore_cur", cur_tap, 20);
    check("ignore_done_count", done_cnt - b_done, 1);
    check("ignore_busy", busy, 0);

    snap();
    @(negedge CLK);
    req_valid = 1'b1; req_tap = 9'd30; req_load = 1'b0;
    @(posedge CLK); #1;
    req_valid = 1'b0;
    n = 0;
    while (ce_times.size() == b_ce && n < 200) begin @(negedge CLK); n++; end
    check("rst_mid_first_ce", n < 200, 1);
    @(posedge CLK); #2;
    RST = 1'b1;
    #1;
    check("rst_mid_busy", busy, 0);
    check("rst_mid_ready", req_ready, 1);
    check("rst_mid_en_vtc", dly_en_vtc, 1);
    check("rst_mid_cur", cur_tap, 0);
    check("rst_mid_ce", dly_ce, 0);
    @(negedge CLK);
    RST = 1'b0;
    repeat (40) @(negedge CLK);
    check("rst_mid_no_done", done_cnt - b_done, 0);
    check("rst_mid_idle", busy, 0);

    check("strobe_rules", strobe_bad, 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
